fma_round_arbiter: RTL

- Shares one pipelined rounding stage between two FMA lanes in the coprocessor.
- Each lane presents an unrounded result: sign, biased exponent, and a kept mantissa plus guard, round and sticky bits.
- A round-robin arbiter picks one request per cycle. A 2-stage pipeline computes the round-up decision and the increment, and handles mantissa carry-out and exponent overflow.
- Also holds the programmable rounding-mode register, with safe (drained) mode switching.

---
 rtl/fma_round_arbiter.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/fma_round_arbiter.sv
// Two-lane round-robin front end feeding a shared 2-stage FP rounding pipeline with a drained rounding-mode register.
// Optional macro ROUND_INEXACT_FLAG_EN adds the out_inexact result flag.
module fma_round_arbiter #(
    parameter int MW = 24,
    parameter int EW = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0]            req_sign,
    input  logic [2*EW-1:0]       req_exp,
    input  logic [2*(MW+3)-1:0]   req_mant,
    input  logic                  cfg_we,
    input  logic [1:0]            cfg_mode,
    output logic                  cfg_busy,
    output logic [1:0]            cur_mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_lane,
    output logic                  out_sign,
    output logic [EW-1:0]         out_exp,
    output logic [MW-1:0]         out_mant,
`ifdef ROUND_INEXACT_FLAG_EN
    output logic                  out_ovf,
    output logic                  out_inexact
`else
    output logic                  out_ovf
`endif
);

    localparam int RW = MW + 3;

    typedef enum logic [1:0] {
        ModeTrunc    = 2'b00,
        ModePosInf   = 2'b01,
        ModeNegInf   = 2'b10,
        ModeNearEven = 2'b11
    } roundMode_e;

    roundMode_e     modeReg;
    logic [1:0]     pendMode;
    logic           busyReg;
    logic           prioLane;

    logic           stall;
    logic           pipeEmpty;
    logic           grantLane;
    logic           accept;

    logic           selSign;
    logic [EW-1:0]  selExp;
    logic [RW-1:0]  selMant;
    logic           selTail;
    logic           selRndUp;

    logic           s1Valid;
    logic           s1Lane;
    logic           s1Sign;
    logic [EW-1:0]  s1Exp;
    logic [MW-1:0]  s1Kept;
    logic           s1RndUp;

    logic [MW:0]    sumMant;
    logic [EW-1:0]  expInc;
    logic [EW-1:0]  rExp;
    logic [MW-1:0]  rMant;
    logic           rOvf;

    assign stall     = out_valid & ~out_ready;
    assign pipeEmpty = ~s1Valid & ~out_valid;
    assign cfg_busy  = busyReg;
    assign cur_mode  = modeReg;

    // Contention goes to the preferred lane; a lone requester wins outright.
    always_comb begin
        grantLane = prioLane;
        if (req_valid == 2'b01) begin
            grantLane = 1'b0;
        end else if (req_valid == 2'b10) begin
            grantLane = 1'b1;
        end
        req_ready = 2'b00;
        if (!stall && !busyReg && req_valid[grantLane]) begin
            req_ready[grantLane] = 1'b1;
        end
    end

    assign accept  = |(req_valid & req_ready);
    assign selSign = req_sign[grantLane];
    assign selExp  = grantLane ? req_exp[2*EW-1:EW] : req_exp[EW-1:0];
    assign selMant = grantLane ? req_mant[2*RW-1:RW] : req_mant[RW-1:0];
    assign selTail = |selMant[2:0];

    always_comb begin
        selRndUp = 1'b0;
        case (modeReg)
            ModeTrunc:    selRndUp = 1'b0;
            ModePosInf:   selRndUp = ~selSign & selTail;
            ModeNegInf:   selRndUp = selSign & selTail;
            ModeNearEven: selRndUp = selMant[2] & (selMant[3] | selMant[1] | selMant[0]);
            default:      selRndUp = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prioLane <= 1'b0;
        end else if (accept) begin
            prioLane <= ~grantLane;
        end
    end

    // A write while busy just replaces the pending value; it lands once both stages are empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            modeReg  <= ModeNearEven;
            pendMode <= 2'b11;
            busyReg  <= 1'b0;
        end else if (cfg_we) begin
            pendMode <= cfg_mode;
            busyReg  <= 1'b1;
        end else if (busyReg && pipeEmpty) begin
            modeReg  <= roundMode_e'(pendMode);
            busyReg  <= 1'b0;
        end
    end

    // The round-up decision is frozen here so later mode changes cannot affect this op.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1Valid <= 1'b0;
            s1Lane  <= 1'b0;
            s1Sign  <= 1'b0;
            s1Exp   <= '0;
            s1Kept  <= '0;
            s1RndUp <= 1'b0;
        end else if (!stall) begin
            s1Valid <= accept;
            if (accept) begin
                s1Lane  <= grantLane;
                s1Sign  <= selSign;
                s1Exp   <= selExp;
                s1Kept  <= selMant[RW-1:3];
                s1RndUp <= selRndUp;
            end
        end
    end

    assign sumMant = {1'b0, s1Kept} + {{MW{1'b0}}, s1RndUp};
    assign expInc  = s1Exp + {{(EW-1){1'b0}}, 1'b1};

    always_comb begin
        rExp  = s1Exp;
        rMant = sumMant[MW-1:0];
        rOvf  = 1'b0;
        if (s1Exp == {EW{1'b1}}) begin
            rMant = s1Kept;
        end else if (sumMant[MW]) begin
            rExp  = expInc;
            rMant = {1'b1, {(MW-1){1'b0}}};
            if (expInc == {EW{1'b1}}) begin
                rOvf  = 1'b1;
                rMant = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_lane  <= 1'b0;
            out_sign  <= 1'b0;
            out_exp   <= '0;
            out_mant  <= '0;
            out_ovf   <= 1'b0;
        end else if (!stall) begin
            out_valid <= s1Valid;
            if (s1Valid) begin
                out_lane <= s1Lane;
                out_sign <= s1Sign;
                out_exp  <= rExp;
                out_mant <= rMant;
                out_ovf  <= rOvf;
            end
        end
    end

`ifdef ROUND_INEXACT_FLAG_EN
    logic s1Inexact;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1Inexact   <= 1'b0;
            out_inexact <= 1'b0;
        end else if (!stall) begin
            if (accept) begin
                s1Inexact <= selTail;
            end
            if (s1Valid) begin
                out_inexact <= s1Inexact | rOvf;
            end
        end
    end
`endif

endmodule
